multi_cycle_control: RTL
========================

Name: multi_cycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle opcode decoding with a state machine that steps each instruction through FETCH, DECODE, EXEC/ADDR, MEM and WB. Memory accesses are gated by a ready handshake. Supported opcodes are R-type, addiu, sw, lw and ori. Any other opcode is reported as illegal and the instruction is skipped.

Parameters:
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
Opcode  input  6  instruction[31:26] from the IR; sampled only in DECODE
mem_ready  input  1  memory completes the current access this cycle
PC_w  output  1  PC <= PC+4 (pulse)
IR_w  output  1  IR <= memory data (pulse)
I_or_D  output  1  memory address source: 0=PC, 1=ALU result register
Mem_r  output  1  memory read request
Mem_w  output  1  memory write request
Reg_w  output  1  register file write enable
Reg_dst  output  1  write register: 1=rd, 0=rt
ALU_src  output  1  ALU B operand: 1=sign/zero-extended immediate, 0=rt
Mem_to_reg  output  1  write-back data: 1=memory data register, 0=ALU result register
ALU_op  output  2  00 idle, 01 add (addiu/lw/sw), 10 R-type funct, 11 or (ori)
illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode
busy_state  output  4  current state encoding (debug)
retired  output  CNT_W  count of completed instructions

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9.
- Reset: while rst=1 at a rising edge, state <= FETCH, opcode register <= 0, retired <= 0.
- Reset gating: while rst is high, every control output and illegal is forced to 0 combinationally. busy_state reads 0.
- Reset has priority over every transition and takes effect mid-instruction. Any pending memory access is abandoned.
- Output timing: control outputs are Moore, decoded from state and the latched opcode. The exceptions are PC_w, IR_w and the MEM_WR completion, which are qualified by mem_ready.
- FETCH: Mem_r=1, I_or_D=0.
  - mem_ready=0: hold in FETCH.
  - mem_ready=1: IR_w=1 and PC_w=1 in the same cycle; next state is DECODE.
- DECODE: latch Opcode. Next state by opcode:
  - 000000 -> EXEC_R
  - 001001 or 001101 -> EXEC_I
  - 100011 or 101011 -> MEM_ADDR
  - anything else -> illegal=1 this cycle, next state FETCH, retired unchanged.
- EXEC_R: ALU_src=0, ALU_op=10 -> WB_R.
- WB_R: Reg_w=1, Reg_dst=1, Mem_to_reg=0, ALU_op=10 -> FETCH.
- EXEC_I: ALU_src=1; ALU_op=01 (addiu) or 11 (ori) -> WB_I.
- WB_I: Reg_w=1, Reg_dst=0, Mem_to_reg=0, ALU_src=1, ALU_op held from EXEC_I -> FETCH.
- MEM_ADDR: ALU_src=1, ALU_op=01 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: Mem_r=1, I_or_D=1. Hold until mem_ready=1, then -> WB_MEM.
- WB_MEM: Reg_w=1, Reg_dst=0, Mem_to_reg=1 -> FETCH.
- MEM_WR: Mem_w=1, I_or_D=1. Hold until mem_ready=1, then -> FETCH.
- Memory request rules: Mem_r and Mem_w are never asserted together. Mem_r and Mem_w stay asserted steadily while waiting on mem_ready.
- Retired counter: increments by 1 on the clock edge leaving WB_R, WB_I or WB_MEM, and on the edge leaving MEM_WR with mem_ready=1. It wraps from all-ones to 0 silently.
- Default outputs: every output not listed for a state is 0.
- Cycle counts with mem_ready tied to 1:
  - R-type, addiu, ori: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - illegal: 2 cycles
- Each wait cycle on mem_ready adds exactly 1 cycle.
- Opcode changes outside DECODE have no effect.
- Unused state encodings 10–15 go to FETCH on the next edge with all outputs 0.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release with mem_ready=1 and Opcode=000000 -> all outputs 0 during reset; states 0,1,2,7,0 follow; Reg_w=1 and Reg_dst=1 only in state 7; retired=1 after 4 cycles.
- lw with memory waits: Opcode=100011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD -> IR_w/PC_w pulse once; Mem_r=1 and I_or_D=1 held 4 cycles in state 5; WB_MEM has Mem_to_reg=1 and Reg_w=1; total 10 cycles; retired +1.
- sw then ori back-to-back, mem_ready=1 -> sw: Mem_w=1 for exactly 1 cycle and Reg_w never set. ori: ALU_op=11 in states 3 and 8, Reg_dst=0. retired +2 after 8 cycles.
- Illegal opcode 000010 -> illegal=1 for one cycle in DECODE; FETCH on the next cycle; retired unchanged; Reg_w, Mem_w and Mem_r are 0 in DECODE.
- Reset mid-operation: assert rst in MEM_WR with mem_ready=0 -> Mem_w drops to 0 the same cycle; state=0 after the edge; retired=0; no write occurs.
- Counter wrap with CNT_W=4: run 16 addiu (001001) instructions -> retired reads 0 after the 16th and 1 after the 17th.

Source files
------------

// File: rtl/multi_cycle_control_if.sv
// Memory handshake between the multi-cycle sequencer and instruction/data memory.
// The controller drives the request and address-select lines; memory returns mem_ready.
interface multi_cycle_control_if;
  logic Mem_r;
  logic Mem_w;
  logic I_or_D;
  logic mem_ready;

  modport master (output Mem_r, output Mem_w, output I_or_D, input mem_ready);
  modport slave  (input Mem_r, input Mem_w, input I_or_D, output mem_ready);
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB state machine with
// registered Moore controls, ready-gated memory accesses and a retired-instruction count.
module multi_cycle_control #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_cycle_control_if.master mem,
  input  logic [5:0]            Opcode,
  output logic                  PC_w,
  output logic                  IR_w,
  output logic                  Reg_w,
  output logic                  Reg_dst,
  output logic                  ALU_src,
  output logic                  Mem_to_reg,
  output logic [1:0]            ALU_op,
  output logic                  illegal,
  output logic [3:0]            busy_state,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       i_or_d;
    logic       mem_r;
    logic       mem_w;
    logic       reg_w;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a state; the opcode only matters for the I-type ALU op.
  function automatic ctrl_t decode_ctrl(state_t s, logic [5:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    c.mem_r = 1'b1;
      EXEC_R:   c.alu_op = 2'b10;
      WB_R:     begin c.reg_w = 1'b1; c.reg_dst = 1'b1; c.alu_op = 2'b10; end
      EXEC_I:   begin c.alu_src = 1'b1; c.alu_op = (opc == OP_ORI) ? 2'b11 : 2'b01; end
      WB_I:     begin
                  c.reg_w   = 1'b1;
                  c.alu_src = 1'b1;
                  c.alu_op  = (opc == OP_ORI) ? 2'b11 : 2'b01;
                end
      MEM_ADDR: begin c.alu_src = 1'b1; c.alu_op = 2'b01; end
      MEM_RD:   begin c.mem_r = 1'b1; c.i_or_d = 1'b1; end
      MEM_WR:   begin c.mem_w = 1'b1; c.i_or_d = 1'b1; end
      WB_MEM:   begin c.reg_w = 1'b1; c.mem_to_reg = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t     state, state_nxt;
  logic [5:0] opc_q, opc_nxt;
  ctrl_t      ctrl_q;
  logic       op_legal;
  logic       retire;

  assign op_legal = (Opcode == OP_RTYPE) || (Opcode == OP_ADDIU) || (Opcode == OP_ORI) ||
                    (Opcode == OP_LW)    || (Opcode == OP_SW);

  assign retire = (state == WB_R) || (state == WB_I) || (state == WB_MEM) ||
                  ((state == MEM_WR) && mem.mem_ready);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = FETCH;
    opc_nxt   = opc_q;
    case (state)
      FETCH:    state_nxt = mem.mem_ready ? DECODE : FETCH;
      DECODE: begin
        opc_nxt = Opcode;
        case (Opcode)
          OP_RTYPE:        state_nxt = EXEC_R;
          OP_ADDIU, OP_ORI: state_nxt = EXEC_I;
          OP_LW, OP_SW:    state_nxt = MEM_ADDR;
          default:         state_nxt = FETCH;
        endcase
      end
      EXEC_R:   state_nxt = WB_R;
      EXEC_I:   state_nxt = WB_I;
      MEM_ADDR: state_nxt = (opc_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   state_nxt = mem.mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   state_nxt = mem.mem_ready ? FETCH : MEM_WR;
      default:  state_nxt = FETCH;
    endcase
  end

  // Controls are registered from the next state so they line up with the state register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      opc_q   <= '0;
      ctrl_q  <= decode_ctrl(FETCH, '0);
      retired <= '0;
    end else begin
      state  <= state_nxt;
      opc_q  <= opc_nxt;
      ctrl_q <= decode_ctrl(state_nxt, opc_nxt);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Reset forces every control low immediately, abandoning any pending access.
  assign mem.Mem_r   = ctrl_q.mem_r  & ~rst;
  assign mem.Mem_w   = ctrl_q.mem_w  & ~rst;
  assign mem.I_or_D  = ctrl_q.i_or_d & ~rst;
  assign Reg_w       = ctrl_q.reg_w      & ~rst;
  assign Reg_dst     = ctrl_q.reg_dst    & ~rst;
  assign ALU_src     = ctrl_q.alu_src    & ~rst;
  assign Mem_to_reg  = ctrl_q.mem_to_reg & ~rst;
  assign ALU_op      = rst ? 2'b00 : ctrl_q.alu_op;
  assign PC_w        = ~rst & (state == FETCH) & mem.mem_ready;
  assign IR_w        = ~rst & (state == FETCH) & mem.mem_ready;
  assign illegal     = ~rst & (state == DECODE) & ~op_legal;
  assign busy_state  = rst ? 4'd0 : state;

endmodule
